// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit: byte/half/word/dword loads and stores over a valid/ack bus.
// Define SPLIT_MISALIGNED_EN to run bus-word-crossing accesses as two beats instead of rejecting them.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  err_align,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_byteen,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sign;
    logic [OFF_W-1:0]    r_off;
    logic                r_err;
    logic [2*DATA_W-1:0] r_cap;

    logic [OFF_W-1:0]    w_off;
    logic [3:0]          w_bytes;
    logic [4:0]          w_end;
    logic                w_cross;
    logic                w_oversize;
    logic                w_err;
    logic [ADDR_W-1:0]   w_base;
    logic [DATA_W-1:0]   w_wdata0;
    logic [NB-1:0]       w_lanes0;
    logic [DATA_W-1:0]   w_raw;

    assign w_off      = req_addr[OFF_W-1:0];
    assign w_bytes    = 4'd1 << req_size;
    assign w_end      = 5'(w_off) + 5'(w_bytes);
    assign w_cross    = w_end > 5'(NB);
    assign w_oversize = w_bytes > 4'(NB);
    assign w_base     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef SPLIT_MISALIGNED_EN
    logic                r_cross;
    logic [DATA_W-1:0]   r_whi;
    logic [NB-1:0]       r_behi;
    logic [2*DATA_W-1:0] w_wsh;
    logic [2*NB-1:0]     w_lanes;

    // Shift across a double-width window so the second beat's bytes fall in the upper half
    assign w_wsh    = {{DATA_W{1'b0}}, req_wdata} << {w_off, 3'b000};
    assign w_lanes  = (((2*NB)'(1) << w_bytes) - (2*NB)'(1)) << w_off;
    assign w_wdata0 = w_wsh[DATA_W-1:0];
    assign w_lanes0 = w_lanes[NB-1:0];
    assign w_err    = w_oversize;
`else
    assign w_wdata0 = req_wdata << {w_off, 3'b000};
    assign w_lanes0 = ((NB'(1) << w_bytes) - NB'(1)) << w_off;
    assign w_err    = w_oversize | w_cross;
`endif

    function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic sgn);
        logic [DATA_W-1:0] res;
        int                nbits;
        logic              msb;
        nbits = 8 << size;
        if (nbits > DATA_W) nbits = DATA_W;
        msb = raw[nbits-1];
        for (int i = 0; i < DATA_W; i++) res[i] = (i < nbits) ? raw[i] : (sgn & msb);
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_byteen <= '0;
            bus_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_err) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state    <= S_BEAT0;
                            bus_req    <= 1'b1;
                            bus_we     <= req_we;
                            bus_addr   <= w_base;
                            bus_byteen <= w_lanes0;
                            bus_wdata  <= req_we ? w_wdata0 : '0;
                        end
                    end
                end
                S_BEAT0: begin
                    if (bus_ack) begin
                        r_state    <= S_DONE;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_byteen <= '0;
                        bus_wdata  <= '0;
`ifdef SPLIT_MISALIGNED_EN
                        if (r_cross) begin
                            r_state    <= S_BEAT1;
                            bus_req    <= 1'b1;
                            bus_we     <= r_we;
                            bus_addr   <= bus_addr + ADDR_W'(NB);
                            bus_byteen <= r_behi;
                            bus_wdata  <= r_whi;
                        end
`endif
                    end
                end
`ifdef SPLIT_MISALIGNED_EN
                S_BEAT1: begin
                    if (bus_ack) begin
                        r_state    <= S_DONE;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_byteen <= '0;
                        bus_wdata  <= '0;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request attributes and captured read beats carry no reset; they are only read after a latch
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req_valid) begin
            r_we   <= req_we;
            r_size <= req_size;
            r_sign <= req_sign;
            r_off  <= w_off;
            r_err  <= w_err;
            r_cap  <= '0;
`ifdef SPLIT_MISALIGNED_EN
            r_cross <= w_cross;
            r_whi   <= req_we ? w_wsh[2*DATA_W-1:DATA_W] : '0;
            r_behi  <= w_lanes[2*NB-1:NB];
`endif
        end
        if (r_state == S_BEAT0 && bus_ack) r_cap[DATA_W-1:0] <= bus_rdata;
`ifdef SPLIT_MISALIGNED_EN
        if (r_state == S_BEAT1 && bus_ack) r_cap[2*DATA_W-1:DATA_W] <= bus_rdata;
`endif
    end

    assign w_raw     = DATA_W'(r_cap >> {r_off, 3'b000});
    assign stall     = req_valid && (r_state != S_DONE);
    assign rsp_valid = (r_state == S_DONE);
    assign err_align = (r_state == S_DONE) && r_err;
    assign rsp_rdata = (r_state == S_DONE && !r_err && !r_we) ? f_extend(w_raw, r_size, r_sign) : '0;

endmodule
